// File: rtl/serial_subtractor_pkg.sv
// Shared definitions for the bit-serial subtractor: FSM state encoding and default width.
package serial_subtractor_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    localparam int unsigned DEFAULT_WIDTH = 8;

endpackage

// File: rtl/serial_subtractor_half_subtractor.sv
// Combinational half-subtractor cell: difference and borrow-out of x - y.
module half_subtractor (
    output logic d,
    output logic bo,
    input  logic x,
    input  logic y
);

    assign d  = x ^ y;
    assign bo = ~x & y;

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial subtractor: diff = a - b, LSB first, one bit per clock, start/busy/done handshake.
module serial_subtractor
    import serial_subtractor_pkg::*;
#(
    parameter int unsigned WIDTH = DEFAULT_WIDTH,
    parameter int unsigned CNT_W = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             borrow
);

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   sa_q, sa_d;
    logic [WIDTH-1:0]   sb_q, sb_d;
    logic [WIDTH-1:0]   res_q, res_d;
    logic [WIDTH-1:0]   diff_q, diff_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               bf_q, bf_d;
    logic               borrow_q, borrow_d;
    logic               done_q, done_d;

    // Full-subtract stage: two half-subtractors plus an OR for the borrow.
    logic d1, b1, dbit, b2, bout;

    half_subtractor u_hs_xy (
        .d  (d1),
        .bo (b1),
        .x  (sa_q[0]),
        .y  (sb_q[0])
    );

    half_subtractor u_hs_bin (
        .d  (dbit),
        .bo (b2),
        .x  (d1),
        .y  (bf_q)
    );

    assign bout = b1 | b2;

    always_comb begin
        state_d  = state_q;
        sa_d     = sa_q;
        sb_d     = sb_q;
        res_d    = res_q;
        diff_d   = diff_q;
        cnt_d    = cnt_q;
        bf_d     = bf_q;
        borrow_d = borrow_q;
        done_d   = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    sa_d    = a;
                    sb_d    = b;
                    bf_d    = 1'b0;
                    cnt_d   = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                sa_d  = sa_q >> 1;
                sb_d  = sb_q >> 1;
                res_d = {dbit, res_q[WIDTH-1:1]};
                bf_d  = bout;
                cnt_d = cnt_q + CNT_W'(1);
                // Final bit: publish the result straight from the shift path.
                if (cnt_q == CNT_W'(WIDTH - 1)) begin
                    diff_d   = {dbit, res_q[WIDTH-1:1]};
                    borrow_d = bout;
                    done_d   = 1'b1;
                    state_d  = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            sa_q     <= '0;
            sb_q     <= '0;
            res_q    <= '0;
            diff_q   <= '0;
            cnt_q    <= '0;
            bf_q     <= 1'b0;
            borrow_q <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            sa_q     <= sa_d;
            sb_q     <= sb_d;
            res_q    <= res_d;
            diff_q   <= diff_d;
            cnt_q    <= cnt_d;
            bf_q     <= bf_d;
            borrow_q <= borrow_d;
            done_q   <= done_d;
        end
    end

    assign busy   = (state_q == RUN);
    assign done   = done_q;
    assign diff   = diff_q;
    assign borrow = borrow_q;

endmodule
